// File: rtl/muxa_sequencer_pkg.sv
// Shared CPU package: op_class and A-mux select encodings plus sequencer state codes.
// The optional branch-target phase is enabled by defining MUXA_SEQ_BRANCH_EN.
package muxa_sequencer_pkg;

    typedef logic [2:0] op_class_t;
    typedef logic [1:0] muxa_sel_t;
    typedef logic [2:0] seq_state_t;

    localparam op_class_t OP_ALU_RS    = 3'd0;
    localparam op_class_t OP_SHIFT_IMM = 3'd1;
    localparam op_class_t OP_SHIFT_VAR = 3'd2;
    localparam op_class_t OP_PC_LINK   = 3'd3;
    localparam op_class_t OP_NO_WB     = 3'd4;
    localparam op_class_t OP_BRANCH    = 3'd5;

    localparam muxa_sel_t MUXA_RS    = 2'b00;
    localparam muxa_sel_t MUXA_SRC   = 2'b01;
    localparam muxa_sel_t MUXA_SHAMT = 2'b10;
    localparam muxa_sel_t MUXA_PC    = 2'b11;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_PCINC = 3'd1;
    localparam seq_state_t ST_EXEC  = 3'd2;
    localparam seq_state_t ST_BTGT  = 3'd3;
    localparam seq_state_t ST_WB    = 3'd4;

    // Classes 0-3 produce a register result; 6-7 are undefined encodings.
    function automatic logic class_writes_rf(op_class_t cls);
        return cls <= OP_PC_LINK;
    endfunction

    function automatic logic class_is_illegal(op_class_t cls);
        return cls > OP_BRANCH;
    endfunction

endpackage

// File: rtl/muxa_sel_decode.sv
// Maps (sequencer state, instruction class) to the ALU A-operand mux select.
// Purely combinational so the forwarding unit can share it.
module muxa_sel_decode
    import muxa_sequencer_pkg::*;
(
    input  logic [2:0] state,
    input  logic [2:0] cls,
    output logic [1:0] muxa_ctr
);

    always_comb begin
        muxa_ctr = MUXA_RS;
        case (state)
            ST_PCINC, ST_BTGT: muxa_ctr = MUXA_PC;
            ST_EXEC: begin
                case (cls)
                    OP_SHIFT_VAR: muxa_ctr = MUXA_SRC;
                    OP_SHIFT_IMM: muxa_ctr = MUXA_SHAMT;
                    OP_PC_LINK:   muxa_ctr = MUXA_PC;
                    default:      muxa_ctr = MUXA_RS;
                endcase
            end
            default: muxa_ctr = MUXA_RS;
        endcase
    end

endmodule

// File: rtl/muxa_sequencer.sv
// Multi-cycle phase sequencer driving the A-operand select and datapath enables.
// Define MUXA_SEQ_BRANCH_EN to add the BTGT phase that rewrites PC for BRANCH.
module muxa_sequencer
    import muxa_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] op_class,
    input  logic       ex_stall,
    output logic [1:0] muxa_ctr,
    output logic       alu_en,
    output logic       pc_we,
    output logic       rf_we,
    output logic       done,
    output logic       illegal
);

    seq_state_t state_q, state_d;
    op_class_t  cls_q, cls_d;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    cls_d   = op_class;
                    state_d = ST_PCINC;
                end
            end
            ST_PCINC: state_d = ST_EXEC;
            ST_EXEC: begin
                if (!ex_stall) begin
`ifdef MUXA_SEQ_BRANCH_EN
                    state_d = (cls_q == OP_BRANCH) ? ST_BTGT : ST_WB;
`else
                    state_d = ST_WB;
`endif
                end
            end
`ifdef MUXA_SEQ_BRANCH_EN
            ST_BTGT: state_d = ST_WB;
`endif
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= OP_ALU_RS;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Every output is a function of registered state only.
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        alu_en      = (state_q == ST_PCINC) || (state_q == ST_EXEC) || (state_q == ST_BTGT);
        pc_we       = (state_q == ST_PCINC) || (state_q == ST_BTGT);
        done        = (state_q == ST_WB);
        rf_we       = (state_q == ST_WB) && class_writes_rf(cls_q);
        illegal     = (state_q == ST_WB) && class_is_illegal(cls_q);
    end

    muxa_sel_decode u_sel_decode (
        .state    (state_q),
        .cls      (cls_q),
        .muxa_ctr (muxa_ctr)
    );

endmodule

// File: doc/muxa_sequencer.md
# muxa_sequencer

Multi-cycle phase sequencer for the ALU A-operand select. It accepts one decoded instruction class per handshake and steps through PC-increment, execute and write-back phases. In each phase it drives the 2-bit select of the A-operand mux (rs / shift source / zero-extended shamt / PC) plus the matching ALU, PC and register-file enables. It sits between the instruction decoder and the execute datapath of the multi-cycle CPU.

## Interface
- Parameters: none.
- Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  decoder presents an instruction class
- instr_ready  out  1  sequencer can accept (high only in IDLE)
- op_class  in  3  0 ALU_RS, 1 SHIFT_IMM, 2 SHIFT_VAR, 3 PC_LINK, 4 NO_WB, 5 BRANCH, 6–7 illegal
- ex_stall  in  1  hold EXEC (multi-cycle ALU/memory not done)
- muxa_ctr  out  2  A-mux select: 00 rs, 01 shift source, 10 {27'b0, shift source[4:0]}, 11 PC
- alu_en  out  1  ALU result capture
- pc_we  out  1  PC register write
- rf_we  out  1  register-file write
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse with done for op_class 6–7

## Operation
- States: IDLE, PCINC, EXEC, BTGT (only with macro), WB.
- IDLE: instr_ready=1, muxa_ctr=00, enables 0. On instr_valid&&instr_ready, latch op_class and go to PCINC.
- PCINC: muxa_ctr=11, alu_en=1, pc_we=1. Next state is EXEC.
- EXEC: muxa_ctr by class: ALU_RS/NO_WB/BRANCH/illegal→00, SHIFT_VAR→01, SHIFT_IMM→10, PC_LINK→11. alu_en=1.
  - ex_stall=1: stay in EXEC, outputs held.
  - Otherwise: BRANCH goes to BTGT when macro is defined; every other class goes to WB.
- WB: rf_we=1 for classes 0–3 only. done=1. illegal=1 for classes 6–7. Next state is IDLE.
- instr_valid outside IDLE is ignored; op_class is sampled only at accept.
- Encodings are fixed. No other select value is ever driven.

## Timing
- Reset state IDLE. Reset values: instr_ready=1, muxa_ctr=00, alu_en=pc_we=rf_we=done=illegal=0.
- All outputs decode from the registered state and latched class. No input→output combinational path.
- Latency: accept at edge N. PCINC in N+1, EXEC in N+2, WB/done in N+3, IDLE again in N+4.
- Each ex_stall cycle adds one cycle. BRANCH with macro defined adds one cycle (BTGT).
- Back-to-back throughput: one instruction per 4 cycles, since ready rises in the cycle after done.
- rst mid-operation: IDLE on the next edge. The instruction is abandoned with no done and no rf_we. A pc_we already issued is not undone.
- rst and instr_valid together: rst wins, nothing accepted.

## Configuration
- MUXA_SEQ_BRANCH_EN defined:
  - BRANCH goes EXEC→BTGT→WB.
  - BTGT: muxa_ctr=11, alu_en=1, pc_we=1, so the ALU forms PC+offset for the branch target.
  - ex_stall has no effect in BTGT.
- Undefined:
  - BTGT does not exist.
  - BRANCH behaves as NO_WB: compare only, no PC rewrite.

## Structure
- Shared CPU package holds:
  - op_class encodings
  - muxa_ctr encodings (MUXA_RS=2'b00, MUXA_SRC=2'b01, MUXA_SHAMT=2'b10, MUXA_PC=2'b11)
  - the state enum
- One combinational sub-module, muxa_sel_decode, maps (state, class) → muxa_ctr. It is reused by the forwarding unit. The rest of the block is a flat FSM.

## Test plan
- Reset, then idle: with rst high 2 cycles then low, instr_ready=1, muxa_ctr=00, all enables 0, no done.
- SHIFT_IMM accepted at cycle 0: cycle 1 muxa_ctr=11 with pc_we=1; cycle 2 muxa_ctr=10 with alu_en=1; cycle 3 rf_we=1 and done=1; cycle 4 instr_ready=1.
- SHIFT_VAR with ex_stall high for 3 EXEC cycles: muxa_ctr holds 01 for 4 cycles; done arrives at cycle 6.
- BRANCH: with macro defined, EXEC ctr=00, then BTGT ctr=11 with pc_we=1, then done at cycle 4 with rf_we=0. Without the macro, done at cycle 3 with rf_we=0.
- op_class=7: ctr=00 in EXEC; done and illegal pulse together at cycle 3; rf_we=0.
- rst asserted while in EXEC: next cycle IDLE, no done, no rf_we. A new instruction accepted afterwards completes normally.
